// File: rtl/cpu_trace_pkg.sv
// Shared types for the mini-CPU trace capture block.
// The TRACE_TIMESTAMP_EN build adds a TS_W-bit timestamp to every entry.
`timescale 1ns/1ps
package cpu_trace_pkg;

   localparam int unsigned TS_W       = 16;
   localparam int unsigned ST_W       = 3;
   localparam int unsigned DEF_PC_W   = 8;
   localparam int unsigned DEF_IR_W   = 16;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } trace_state_t;

   // Entry layout of the default core build; rd_data is packed in this order
   typedef struct packed {
      logic [DEF_PC_W-1:0]   pc;
      logic [DEF_IR_W-1:0]   ir;
      logic [DEF_DATA_W-1:0] alu;
   } trace_entry_t;

   function automatic logic is_capturing(trace_state_t s);
      return (s == ARMED) || (s == POST);
   endfunction

endpackage

// File: rtl/cpu_trace_ram.sv
// Simple dual-port trace RAM: one write port, registered read, write-first on collision.
`timescale 1ns/1ps
module cpu_trace_ram #(
   parameter int unsigned W     = 40,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Bypass keeps the registered read write-first without needing a read-during-write RAM mode
   always_ff @(posedge clk) begin
      if (we && (waddr == raddr)) begin
         rdata <= wdata;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/cpu_trace_capture.sv
// Circular instruction trace for the mini CPU: FSM, trigger, pointers and read-back.
// Optional macro TRACE_TIMESTAMP_EN adds a 16-bit cycle timestamp per entry and the rd_ts port.
`timescale 1ns/1ps
module cpu_trace_capture
   import cpu_trace_pkg::*;
#(
   parameter int unsigned PC_W         = 8,
   parameter int unsigned IR_W         = 16,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned POST_TRIG    = 4,
   parameter logic [2:0]  SAMPLE_STATE = 3'd2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ST_W-1:0]                 state_dbg,
   input  logic [PC_W-1:0]                 pc_dbg,
   input  logic [IR_W-1:0]                 ir_dbg,
   input  logic [DATA_W-1:0]               alu_out_dbg,
   input  logic                            arm,
   input  logic                            trig_en,
   input  logic [PC_W-1:0]                 trig_pc,
   input  logic                            trig_force,
   input  logic [$clog2(DEPTH)-1:0]        rd_addr,
   output logic [PC_W+IR_W+DATA_W-1:0]     rd_data,
`ifdef TRACE_TIMESTAMP_EN
   output logic [TS_W-1:0]                 rd_ts,
`endif
   output logic                            rd_valid,
   output logic [$clog2(DEPTH):0]          count,
   output logic                            armed,
   output logic                            triggered,
   output logic                            done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = PC_W + IR_W + DATA_W;
`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned RW = EW + TS_W;
`else
   localparam int unsigned RW = EW;
`endif

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] alu;
   } entry_t;

   trace_state_t  state, state_d;
   logic [AW-1:0] wr_ptr, wr_ptr_d;
   logic [CW-1:0] count_d;
   logic [CW-1:0] post_cnt, post_cnt_d;
   logic          force_pend, force_d;
   logic          we_c;
   logic          sample_c;
   logic          pc_hit_c;
   logic [AW-1:0] rd_phys_c;
   entry_t        entry_c;
   logic [RW-1:0] ram_wdata;
   logic [RW-1:0] ram_q;

   assign sample_c = (state_dbg == SAMPLE_STATE) && is_capturing(state);
   assign pc_hit_c = trig_en && (pc_dbg == trig_pc);
   assign entry_c  = '{pc: pc_dbg, ir: ir_dbg, alu: alu_out_dbg};

   // Next-state, pointer and trigger logic; arm overrides any same-cycle sample
   always_comb begin
      state_d    = state;
      wr_ptr_d   = wr_ptr;
      count_d    = count;
      post_cnt_d = post_cnt;
      force_d    = force_pend | trig_force;
      we_c       = 1'b0;
      if (arm) begin
         state_d    = ARMED;
         wr_ptr_d   = '0;
         count_d    = '0;
         post_cnt_d = '0;
         force_d    = 1'b0;
      end else if (sample_c) begin
         we_c     = 1'b1;
         wr_ptr_d = wr_ptr + AW'(1);
         count_d  = (count == CW'(DEPTH)) ? count : count + CW'(1);
         force_d  = trig_force;
         if (state == ARMED) begin
            if (pc_hit_c || force_pend) begin
               if (POST_TRIG == 0) begin
                  state_d = DONE;
               end else begin
                  state_d    = POST;
                  post_cnt_d = CW'(POST_TRIG);
               end
            end
         end else begin
            post_cnt_d = post_cnt - CW'(1);
            if (post_cnt == CW'(1)) begin
               state_d = DONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         count      <= '0;
         post_cnt   <= '0;
         force_pend <= 1'b0;
         armed      <= 1'b0;
         triggered  <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         wr_ptr     <= wr_ptr_d;
         count      <= count_d;
         post_cnt   <= post_cnt_d;
         force_pend <= force_d;
         armed      <= (state_d == ARMED);
         triggered  <= (state_d == POST);
         done       <= (state_d == DONE);
      end
   end

   // Oldest entry sits count slots behind the write pointer
   assign rd_phys_c = wr_ptr - AW'(count) + rd_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= (CW'(rd_addr) < count);
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign ram_wdata = {ts_q, entry_c};
   assign rd_ts     = rd_valid ? ram_q[RW-1:EW] : '0;
`else
   assign ram_wdata = entry_c;
`endif

   assign rd_data = rd_valid ? ram_q[EW-1:0] : '0;

   cpu_trace_ram #(
      .W     (RW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (we_c),
      .waddr (wr_ptr),
      .wdata (ram_wdata),
      .raddr (rd_phys_c),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture against a queue-based trace model.
// Build with TRACE_TIMESTAMP_EN to also check rd_ts.
`timescale 1ns/1ps
module tb_cpu_trace_capture;
   import cpu_trace_pkg::*;

   localparam int unsigned PC_W      = 8;
   localparam int unsigned IR_W      = 16;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned DEPTH     = 8;
   localparam int unsigned POST_TRIG = 3;
   localparam int unsigned AW        = 3;
   localparam int unsigned EW        = PC_W + IR_W + DATA_W;
   localparam logic [2:0]  SAMP      = 3'd2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [2:0]        state_dbg = '0;
   logic [PC_W-1:0]   pc_dbg = '0;
   logic [IR_W-1:0]   ir_dbg = '0;
   logic [DATA_W-1:0] alu_out_dbg = '0;
   logic              arm = 1'b0;
   logic              trig_en = 1'b0;
   logic [PC_W-1:0]   trig_pc = '0;
   logic              trig_force = 1'b0;
   logic [AW-1:0]     rd_addr = '0;
   logic [EW-1:0]     rd_data;
`ifdef TRACE_TIMESTAMP_EN
   logic [15:0]       rd_ts;
`endif
   logic              rd_valid;
   logic [AW:0]       count;
   logic              armed, triggered, done;

   cpu_trace_capture #(
      .PC_W(PC_W), .IR_W(IR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .POST_TRIG(POST_TRIG), .SAMPLE_STATE(SAMP)
   ) dut (
      .clk(clk), .reset(reset), .state_dbg(state_dbg), .pc_dbg(pc_dbg),
      .ir_dbg(ir_dbg), .alu_out_dbg(alu_out_dbg), .arm(arm), .trig_en(trig_en),
      .trig_pc(trig_pc), .trig_force(trig_force), .rd_addr(rd_addr),
      .rd_data(rd_data),
`ifdef TRACE_TIMESTAMP_EN
      .rd_ts(rd_ts),
`endif
      .rd_valid(rd_valid), .count(count), .armed(armed),
      .triggered(triggered), .done(done)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: the stored trace as a plain queue, oldest first
   typedef struct {
      logic [PC_W-1:0]   pc;
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] alu;
      logic [15:0]       ts;
   } ent_t;

   ent_t mq[$];
   int   m_state = 0;      // 0 idle, 1 armed, 2 post, 3 done
   int   post_left = 0;
   bit   fpend = 1'b0;
   logic [15:0] cyc;

   typedef struct {
      string       name;
      logic        v;
      logic [EW-1:0] d;
      logic [15:0] ts;
      int          cnt;
      logic [2:0]  flags;
   } exp_t;

   exp_t sb[$];
   logic rd_req = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= '0;
      else       cyc <= cyc + 16'd1;
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void m_arm();
      mq.delete();
      m_state   = 1;
      post_left = 0;
      fpend     = 1'b0;
   endfunction

   function automatic void m_sample(ent_t e);
      if (m_state == 1 || m_state == 2) begin
         mq.push_back(e);
         if (mq.size() > DEPTH) void'(mq.pop_front());
         if (m_state == 1) begin
            if ((trig_en && e.pc == trig_pc) || fpend) begin
               if (POST_TRIG == 0) m_state = 3;
               else begin
                  m_state   = 2;
                  post_left = POST_TRIG;
               end
            end
         end else begin
            post_left--;
            if (post_left == 0) m_state = 3;
         end
         fpend = 1'b0;
      end
   endfunction

   task automatic do_cycle(logic [2:0] st, logic [PC_W-1:0] pc);
      ent_t e;
      state_dbg   = st;
      pc_dbg      = pc;
      ir_dbg      = IR_W'($urandom);
      alu_out_dbg = DATA_W'($urandom);
      if (st == SAMP) begin
         e.pc = pc; e.ir = ir_dbg; e.alu = alu_out_dbg; e.ts = cyc;
         m_sample(e);
      end
      @(negedge clk);
   endtask

   task automatic do_arm(bit with_sample);
      arm       = 1'b1;
      state_dbg = with_sample ? SAMP : 3'd0;
      pc_dbg    = PC_W'($urandom);
      m_arm();
      @(negedge clk);
      arm       = 1'b0;
      state_dbg = '0;
   endtask

   task automatic do_force();
      trig_force = 1'b1;
      state_dbg  = '0;
      fpend      = 1'b1;
      @(negedge clk);
      trig_force = 1'b0;
   endtask

   task automatic do_read(int addr);
      exp_t e;
      state_dbg = '0;
      rd_addr   = AW'(addr);
      e.name    = $sformatf("rd%0d", addr);
      e.cnt     = mq.size();
      e.v       = (addr < mq.size());
      e.d       = '0;
      e.ts      = '0;
      if (e.v) begin
         e.d  = {mq[addr].pc, mq[addr].ir, mq[addr].alu};
         e.ts = mq[addr].ts;
      end
      e.flags = {m_state == 3, m_state == 2, m_state == 1};
      sb.push_back(e);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) do_read(i);
   endtask

   // Monitor: compares each presented read response with the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (rd_req) begin
            #1;
            if (sb.size() == 0) begin
               chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_valid"}, 64'(rd_valid), 64'(e.v));
               chk({e.name, "_data"}, 64'(rd_data), 64'(e.d));
               chk({e.name, "_count"}, 64'(count), 64'(e.cnt));
               chk({e.name, "_flags"}, 64'({done, triggered, armed}), 64'(e.flags));
`ifdef TRACE_TIMESTAMP_EN
               chk({e.name, "_ts"}, 64'(rd_ts), 64'(e.ts));
`endif
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      @(negedge clk);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_flags", 64'({done, triggered, armed}), 64'd0);
      chk("reset_rd", 64'({rd_valid, rd_data}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      read_all();

      // PC-match trigger: pcs 1..8 kept, 9..12 ignored
      trig_en = 1'b1;
      trig_pc = 8'd5;
      do_arm(1'b0);
      for (int p = 0; p <= 12; p++) do_cycle(SAMP, PC_W'(p));
      read_all();

      // Trigger on the very first sample
      trig_pc = 8'd0;
      do_arm(1'b0);
      for (int p = 0; p <= 5; p++) do_cycle(SAMP, PC_W'(p));
      for (int i = 0; i <= 4; i++) do_read(i);

      // One entry per instruction while state_dbg cycles
      trig_en = 1'b0;
      do_arm(1'b0);
      for (int n = 0; n < 5; n++)
         for (int s = 0; s < 4; s++) do_cycle(3'(s), PC_W'(8'h40 + n));
      read_all();

      // Forced trigger, then arm during POST, then arm coincident with a sample
      do_force();
      do_cycle(3'd0, 8'd19);
      do_cycle(SAMP, 8'd20);
      do_cycle(SAMP, 8'd21);
      do_read(0);
      do_read(6);
      do_arm(1'b0);
      do_read(0);
      do_cycle(SAMP, 8'd30);
      do_cycle(SAMP, 8'd31);
      do_read(1);
      do_arm(1'b1);
      do_read(0);

      // Randomized capture runs
      for (int r = 0; r < 6; r++) begin
         trig_en = 1'($urandom);
         trig_pc = PC_W'($urandom_range(15, 0));
         do_arm(1'b0);
         for (int c = 0; c < 30; c++) begin
            if ($urandom_range(15, 0) == 0) do_force();
            do_cycle(3'($urandom_range(3, 0)), PC_W'($urandom_range(15, 0)));
         end
         read_all();
         for (int k = 0; k < 4; k++) do_read(int'($urandom_range(DEPTH - 1, 0)));
      end

      // Timestamped samples ten cycles apart
      trig_en = 1'b0;
      do_arm(1'b0);
      for (int n = 0; n < 3; n++) begin
         do_cycle(SAMP, PC_W'(8'h70 + n));
         for (int w = 0; w < 9; w++) do_cycle(3'd0, 8'h00);
      end
      for (int i = 0; i < 3; i++) do_read(i);

      // Reset while in POST returns to IDLE without waiting for a clock
      trig_en = 1'b1;
      trig_pc = 8'd3;
      do_arm(1'b0);
      for (int p = 0; p <= 4; p++) do_cycle(SAMP, PC_W'(p));
      do_read(0);
      #2;
      reset = 1'b1;
      #1;
      chk("midpost_reset_flags", 64'({done, triggered, armed}), 64'd0);
      chk("midpost_reset_count", 64'(count), 64'd0);
      chk("midpost_reset_valid", 64'(rd_valid), 64'd0);
      mq.delete();
      m_state = 0;
      fpend   = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      read_all();

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_trace_capture.md
# cpu_trace_capture

Parametrised trace capture for the mini CPU on the Basys 3 board. It watches the core's debug outputs (state, PC, IR, ALU result) and records one entry per instruction into a circular buffer. Capture stops a programmable number of instructions after a PC-match or forced trigger. The buffer is then read back by index, oldest first. It sits beside `cpu_top`, fed from the same debug nets the bench observes, and makes the same visibility available in hardware.

## Interface
Parameters:
- `PC_W`, 8: PC width.
- `IR_W`, 16: instruction width.
- `DATA_W`, 16: ALU result width.
- `DEPTH`, 16: buffer entries; power of two, ≥ 4.
- `POST_TRIG`, 4: samples stored after the trigger sample; 0 ≤ POST_TRIG ≤ DEPTH-1.
- `SAMPLE_STATE`, 3'd2: `state_dbg` value at which one entry is taken.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `state_dbg`  in  3  core FSM state.
- `pc_dbg`  in  PC_W  core PC.
- `ir_dbg`  in  IR_W  instruction register.
- `alu_out_dbg`  in  DATA_W  ALU result.
- `arm`  in  1  pulse: clear and start capture.
- `trig_en`  in  1  enables the PC-match trigger.
- `trig_pc`  in  PC_W  PC match value.
- `trig_force`  in  1  pulse: trigger on the next sample.
- `rd_addr`  in  $clog2(DEPTH)  read index; 0 = oldest entry.
- `rd_data`  out  PC_W+IR_W+DATA_W  entry packed as {pc, ir, alu}.
- `rd_valid`  out  1  `rd_data` holds a stored entry.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `armed`  out  1  state is ARMED.
- `triggered`  out  1  state is POST.
- `done`  out  1  state is DONE.

## Operation
- **States:**
  - IDLE: no capture.
  - ARMED: recording pre-trigger history; the buffer wraps.
  - POST: recording after the trigger.
  - DONE: frozen; reads only.
- **Sample:** a sample is taken on each rising edge where `state_dbg == SAMPLE_STATE` and the state is ARMED or POST. The entry is written at `wr_ptr`, which then increments modulo DEPTH. `count` increments, saturating at DEPTH.
- **Trigger:** valid only on a sample cycle in ARMED. The condition is (`trig_en` && `pc_dbg == trig_pc`) || a pending force.
  - The trigger sample is stored.
  - POST_TRIG == 0 → DONE directly; otherwise → POST with `post_cnt` = POST_TRIG.
- **Force:** a `trig_force` pulse sets a pending flag. The flag is consumed by the next sample and cleared by `arm`.
- **POST:** each sample decrements `post_cnt`. The sample that brings it to 0 → DONE.
- **arm:** from any state → ARMED. Clears `count`, `wr_ptr`, `post_cnt` and the pending force. An arm has priority over a sample or trigger in the same cycle; that sample is discarded.
- **Read:** physical address = (`wr_ptr` − `count` + `rd_addr`) mod DEPTH.
  - `rd_valid` = (`rd_addr` < `count`).
  - When invalid, `rd_data` = 0.
  - Reads are legal in every state; entries read before DONE may still change.
- **Memory:** contents are not cleared by reset or `arm`. `count` alone gates validity.

## Timing
- **Reset values:** state IDLE; `count`, `armed`, `triggered`, `done`, `rd_valid` and `rd_data` are all 0.
- **Capture:** debug inputs are sampled on the edge itself. `count` and the state flags update on that same edge and are visible the next cycle.
- **Read latency:** 1 cycle. `rd_data`/`rd_valid` for the `rd_addr` presented at edge N appear after edge N. A write to the same address on edge N returns the new data.
- **Trigger to done:** `done` asserts after the edge of the POST_TRIG-th post-trigger sample. The number of cycles depends on the core's CPI.
- **Reset mid-capture:** asynchronous return to IDLE, taking effect immediately.

## Configuration
- **`TRACE_TIMESTAMP_EN` defined:**
  - A free-running 16-bit cycle counter is added. It resets to 0 and wraps 0xFFFF→0.
  - Each entry also stores the counter value at its sample edge.
  - A new output `rd_ts`, 16 bits, follows the same read timing as `rd_data` and is 0 when invalid.
- **Not defined:** there is no counter, no `rd_ts` port, and the RAM width is PC_W+IR_W+DATA_W.

## Structure
- **Package `cpu_trace_pkg`:**
  - `trace_state_t` enum {IDLE, ARMED, POST, DONE}.
  - The packed entry struct, and the timestamp width constant `TS_W` = 16.
  - Inputs `state_dbg`/`pc_dbg`/`ir_dbg`/`alu_out_dbg` keep their stated widths (3 / PC_W / IR_W / DATA_W).
- **Sub-module `cpu_trace_ram`:** simple dual-port RAM, one write port, registered read, write-first on an address collision. It must infer distributed or block RAM.
- **Top level:** FSM, pointers, trigger logic and read address arithmetic.

## Test plan
Bench configuration: DEPTH=8, POST_TRIG=3, SAMPLE_STATE=2. Stimulus drives the debug inputs directly.
- **Reset:** assert `reset` for 20 ns → every output is 0 and `rd_valid` is 0 for all `rd_addr`.
- **PC-match trigger:** arm; `trig_en`=1, `trig_pc`=5; one sample each at pc=0..12 → `done` after the pc=8 sample; `count`=8; `rd_addr` 0..7 return pc 1..8 with ir/alu intact; the pc 9..12 samples are ignored.
- **Early trigger:** arm; `trig_pc`=0, first sample pc=0 → `done` after the 4th sample; `count`=4; `rd_addr`=4 gives `rd_valid`=0 and `rd_data`=0.
- **Sample qualification:** `state_dbg` cycles 0,1,2,3 with pc constant per instruction over 5 instructions, no trigger → `count`=5, exactly one entry per instruction.
- **Force and re-arm:** `trig_force` pulse in ARMED → trigger on the next sample. `arm` during POST → `count`=0 and state ARMED; arm coincident with a sample stores nothing.
- **Reset mid-POST and timestamp:** reset mid-POST → IDLE immediately. With `TRACE_TIMESTAMP_EN`, samples 10 cycles apart give `rd_ts` deltas of 10.
